// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC scheduler slice.
// Angles are 16-bit two's complement with pi = 16'h8000.
// Results are Q.12 with 1.0 = 4096.
package cordic_pkg;

    localparam logic [15:0] ANGLE_PI          = 16'h8000;
    localparam logic [15:0] ANGLE_HALF_PI     = 16'h4000;
    localparam logic [15:0] ANGLE_NEG_HALF_PI = 16'hC000;
    localparam int          Q_ONE             = 4096;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } state_e;

endpackage

// File: rtl/cordic_scheduler_if.sv
// Request/response bus between the requesters and the CORDIC scheduler.
//   req_valid/req_theta/req_ready : per-requester angle handshake (one-hot ready)
//   rsp_valid/rsp_ready           : single result channel with backpressure
//   rsp_id/rsp_sine/rsp_cosine    : result payload
// slave  = scheduler side, master = requester/consumer side.
interface cordic_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int ID_W   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_theta;
    logic [N_REQ-1:0]        req_ready;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_sine;
    logic [DATA_W-1:0]       rsp_cosine;

    modport slave (
        input  req_valid, req_theta, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sine, rsp_cosine
    );

    modport master (
        output req_valid, req_theta, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sine, rsp_cosine
    );
endinterface

// File: rtl/cordic_algorithm.sv
// Iterative rotation-mode CORDIC core, valid for |theta| <= pi/2.
//   clk     : rising-edge clock
//   i_valid : hold high for the whole job; low re-initialises the core
//   theta   : 16-bit angle, pi = 16'h8000
//   sine, cosine : Q.12 results
// The first valid cycle loads the vector, the next 20 iterate, so the result
// is on the outputs during the 22nd valid cycle. Internally 4 extra fraction
// bits keep accumulated truncation well below one output LSB.
module cordic_algorithm (
    input  logic        clk,
    input  logic        i_valid,
    input  logic [15:0] theta,
    output logic [15:0] sine,
    output logic [15:0] cosine
);
    localparam int                 ITERS  = 20;
    // CORDIC gain 0.607253 in Q.16
    localparam logic signed [19:0] K_GAIN = 20'sd39797;

    logic signed [19:0] x_q, y_q;
    logic signed [16:0] z_q;
    logic        [4:0]  step_q;
    logic        [4:0]  iter;
    logic signed [19:0] x_sh, y_sh;

    // atan(2^-i) in angle units (pi = 32768)
    function automatic logic signed [16:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:    return 17'sd8192;
            5'd1:    return 17'sd4836;
            5'd2:    return 17'sd2555;
            5'd3:    return 17'sd1297;
            5'd4:    return 17'sd651;
            5'd5:    return 17'sd326;
            5'd6:    return 17'sd163;
            5'd7:    return 17'sd81;
            5'd8:    return 17'sd41;
            5'd9:    return 17'sd20;
            5'd10:   return 17'sd10;
            5'd11:   return 17'sd5;
            5'd12:   return 17'sd3;
            5'd13:   return 17'sd1;
            5'd14:   return 17'sd1;
            default: return 17'sd0;
        endcase
    endfunction

    assign iter = step_q - 5'd1;
    assign x_sh = x_q >>> iter;
    assign y_sh = y_q >>> iter;

    always_ff @(posedge clk) begin
        if (!i_valid) begin
            step_q <= '0;
        end else if (step_q == 5'd0) begin
            x_q    <= K_GAIN;
            y_q    <= '0;
            z_q    <= {theta[15], theta};
            step_q <= 5'd1;
        end else if (step_q <= 5'(ITERS)) begin
            if (!z_q[16]) begin
                x_q <= x_q - y_sh;
                y_q <= y_q + x_sh;
                z_q <= z_q - atan_lut(iter);
            end else begin
                x_q <= x_q + y_sh;
                y_q <= y_q - x_sh;
                z_q <= z_q + atan_lut(iter);
            end
            step_q <= step_q + 5'd1;
        end
    end

    // Round Q.16 back to Q.12
    assign cosine = 16'((x_q + 20'sd8) >>> 4);
    assign sine   = 16'((y_q + 20'sd8) >>> 4);
endmodule

// File: rtl/cordic_quadrant_fold.sv
// Combinational quadrant folding around a +/-pi/2 CORDIC core.
//   angle_i  -> angle_o, fold_o : angles beyond +/-pi/2 are rotated by pi
//   fold_i, sine_i, cosine_i -> sine_o, cosine_o : undo the rotation by
//   negating both results; negation saturates so the most negative code
//   maps to the most positive one.
module cordic_quadrant_fold
    import cordic_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] angle_i,
    output logic [DATA_W-1:0] angle_o,
    output logic              fold_o,
    input  logic              fold_i,
    input  logic [DATA_W-1:0] sine_i,
    input  logic [DATA_W-1:0] cosine_i,
    output logic [DATA_W-1:0] sine_o,
    output logic [DATA_W-1:0] cosine_o
);
    localparam logic signed [DATA_W-1:0] POS_HALF = DATA_W'(ANGLE_HALF_PI);
    localparam logic signed [DATA_W-1:0] NEG_HALF = DATA_W'(ANGLE_NEG_HALF_PI);
    localparam logic        [DATA_W-1:0] PI       = DATA_W'(ANGLE_PI);

    function automatic logic [DATA_W-1:0] sat_neg(input logic [DATA_W-1:0] v);
        // -(-1.0...) does not fit; clamp to the largest positive code
        return (v == PI) ? ~PI : (DATA_W'(0) - v);
    endfunction

    // The exact boundaries +/-pi/2 stay unfolded; pi itself folds to 0.
    assign fold_o   = ($signed(angle_i) > POS_HALF) || ($signed(angle_i) < NEG_HALF);
    assign angle_o  = fold_o ? (angle_i + PI) : angle_i;

    assign sine_o   = fold_i ? sat_neg(sine_i)   : sine_i;
    assign cosine_o = fold_i ? sat_neg(cosine_i) : cosine_i;
endmodule

// File: rtl/cordic_scheduler.sv
// Round-robin scheduler sharing one CORDIC core among N_REQ requesters.
//   clk, reset_n        : clock, async active-low reset
//   bus (slave)         : request handshake per requester, one response channel
//   core_theta/valid    : drive the shared core (folded angle, i_valid)
//   core_sine/cosine    : raw core results
//   busy                : high whenever a job is in flight or awaiting rsp_ready
// Angles are folded into +/-pi/2 before issue and results sign-corrected on
// capture, giving full-circle coverage from a half-circle core.
module cordic_scheduler
    import cordic_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 16,
    parameter int CORE_CYCLES = 22,
    parameter int ID_W        = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              reset_n,
    cordic_scheduler_if.slave bus,
    output logic [DATA_W-1:0] core_theta,
    output logic              core_valid,
    input  logic [DATA_W-1:0] core_sine,
    input  logic [DATA_W-1:0] core_cosine,
    output logic              busy
);
    localparam int CNT_W = $clog2(CORE_CYCLES);

    state_e            state_q;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              fold_q;
    logic [DATA_W-1:0] core_theta_q;
    logic              core_valid_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [DATA_W-1:0] rsp_sine_q, rsp_cosine_q;
    logic              busy_q;

    logic              grant_vld;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W:0]     cand;
    logic [DATA_W-1:0] sel_theta;
    logic [N_REQ-1:0]  req_ready_d;
    logic [DATA_W-1:0] fold_theta;
    logic              fold_flag;
    logic [DATA_W-1:0] fix_sine, fix_cosine;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ))
                cand = cand - (ID_W+1)'(N_REQ);
            if (!grant_vld && bus.req_valid[cand[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_theta = '0;
        for (int k = 0; k < N_REQ; k++)
            if (grant_id == ID_W'(k))
                sel_theta = bus.req_theta[k*DATA_W +: DATA_W];
    end

    assign rr_ptr_d = (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;

    // Ready is only offered in IDLE and never while reset is asserted.
    always_comb begin
        req_ready_d = '0;
        if (reset_n && state_q == IDLE && grant_vld)
            req_ready_d[grant_id] = 1'b1;
    end

    cordic_quadrant_fold #(.DATA_W(DATA_W)) u_fold (
        .angle_i  (sel_theta),
        .angle_o  (fold_theta),
        .fold_o   (fold_flag),
        .fold_i   (fold_q),
        .sine_i   (core_sine),
        .cosine_i (core_cosine),
        .sine_o   (fix_sine),
        .cosine_o (fix_cosine)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            fold_q       <= 1'b0;
            core_theta_q <= '0;
            core_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_sine_q   <= '0;
            rsp_cosine_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        fold_q       <= fold_flag;
                        core_theta_q <= fold_theta;
                        rsp_id_q     <= grant_id;
                        rr_ptr_q     <= rr_ptr_d;
                        cnt_q        <= '0;
                        core_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_q == CNT_W'(CORE_CYCLES-1)) begin
                        core_valid_q <= 1'b0;
                        rsp_sine_q   <= fix_sine;
                        rsp_cosine_q <= fix_cosine;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    // Core sits with i_valid low here, which re-arms it.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_d;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_sine   = rsp_sine_q;
    assign bus.rsp_cosine = rsp_cosine_q;
    assign core_theta     = core_theta_q;
    assign core_valid     = core_valid_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler driving the real cordic_algorithm core.
module tb_cordic_scheduler;
    import cordic_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int CC  = 22;
    localparam int IW  = 2;
    localparam int TOL = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] core_theta, core_sine, core_cosine;
    logic          core_valid, busy;

    cordic_scheduler_if #(.N_REQ(N), .DATA_W(DW), .ID_W(IW)) sif ();

    cordic_scheduler #(.N_REQ(N), .DATA_W(DW), .CORE_CYCLES(CC), .ID_W(IW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (sif),
        .core_theta  (core_theta),
        .core_valid  (core_valid),
        .core_sine   (core_sine),
        .core_cosine (core_cosine),
        .busy        (busy)
    );

    cordic_algorithm u_core (
        .clk     (clk),
        .i_valid (core_valid),
        .theta   (core_theta),
        .sine    (core_sine),
        .cosine  (core_cosine)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_near(input string nm, input logic [15:0] act, input int exp);
        int a;
        a = int'($signed(act));
        n_cmp++;
        if (a - exp > TOL || exp - a > TOL) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d +/-%0d", nm, a, exp, TOL);
        end
    endtask

    // Issue one request on port p, follow it through RUN and RESP, check
    // grant, folded angle, latency, burst length and the result.
    // Assumes rsp_ready is high and is called shortly after a rising edge.
    task automatic run_job(input int p, input logic [15:0] th, input logic [15:0] ct,
                           input int es, input int ec);
        int n, cyc, cv;
        sif.req_valid[p] = 1'b1;
        sif.req_theta[p*DW +: DW] = th;
        #1;
        n = 0;
        while (!sif.req_ready[p] && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_onehot", sif.req_ready, 1 << p);
        @(posedge clk); #1;
        sif.req_valid[p] = 1'b0;
        chk("core_theta", core_theta, ct);
        chk("busy_run", busy, 1);
        cyc = 1;
        cv  = core_valid ? 1 : 0;
        while (!sif.rsp_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (core_valid) cv++;
        end
        chk("rsp_latency", cyc, CC + 1);
        chk("core_valid_cycles", cv, CC);
        chk("rsp_id", sif.rsp_id, p);
        chk_near("rsp_sine", sif.rsp_sine, es);
        chk_near("rsp_cosine", sif.rsp_cosine, ec);
        @(posedge clk); #1;
        chk("rsp_valid_drop", sif.rsp_valid, 0);
        chk("busy_idle", busy, 0);
    endtask

    typedef struct {
        int          port;
        logic [15:0] theta;
        logic [15:0] core_th;
        int          sin;
        int          cos;
    } vec_t;

    vec_t        vecs[9];
    int          exp_rr_sin[4];
    int          got, run, onehot_bad, t, cyc, bad, seen;
    logic [3:0]  acc;
    logic [15:0] s0, c0;

    initial begin
        reset_n       = 1'b0;
        sif.req_valid = '0;
        sif.req_theta = '0;
        sif.rsp_ready = 1'b1;
        #1;
        chk("rst_core_valid", core_valid, 0);
        chk("rst_rsp_valid", sif.rsp_valid, 0);
        chk("rst_req_ready", sif.req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_core_theta", core_theta, 0);
        chk("rst_rsp_id", sif.rsp_id, 0);
        chk("rst_rsp_sine", sif.rsp_sine, 0);
        chk("rst_rsp_cosine", sif.rsp_cosine, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // port, angle, folded angle, sine, cosine (Q.12)
        vecs[0] = '{0, 16'h1555, 16'h1555,  2048,  3547};  // 30 deg
        vecs[1] = '{2, 16'h6AAB, 16'hEAAB,  2048, -3547};  // 150 deg, folded
        vecs[2] = '{1, ANGLE_HALF_PI, 16'h4000, Q_ONE, 0}; // +90 boundary
        vecs[3] = '{3, ANGLE_PI, 16'h0000, 0, -Q_ONE};     // 180 folds to 0
        vecs[4] = '{0, ANGLE_NEG_HALF_PI, 16'hC000, -Q_ONE, 0};
        vecs[5] = '{1, 16'h0000, 16'h0000, 0, Q_ONE};
        vecs[6] = '{2, 16'hA000, 16'h2000, -2896, -2896};  // -135 deg
        vecs[7] = '{1, 16'h3FFF, 16'h3FFF, Q_ONE, 0};
        vecs[8] = '{3, 16'h4001, 16'hC001, Q_ONE, 0};      // just past +90
        for (int i = 0; i < 9; i++)
            run_job(vecs[i].port, vecs[i].theta, vecs[i].core_th, vecs[i].sin, vecs[i].cos);

        // All four at once; last grant was port 3 so order wraps to 0,1,2,3.
        exp_rr_sin = '{0, 2896, 2896, -2896};
        sif.req_theta = {16'hE000, 16'h6000, 16'h2000, 16'h0000};
        sif.req_valid = 4'hF;
        #1;
        got = 0; run = 0; onehot_bad = 0; t = 0;
        while (got < 4 && t < 200) begin
            acc = sif.req_ready;
            if ($countones(sif.req_ready) > 1) onehot_bad++;
            @(posedge clk); #1;
            sif.req_valid = sif.req_valid & ~acc;
            #1;
            t++;
            if (core_valid) run++;
            else if (run > 0) begin
                chk("burst_len", run, CC);
                run = 0;
            end
            if (sif.rsp_valid) begin
                chk("rr_order", sif.rsp_id, got);
                chk_near("rr_sine", sif.rsp_sine, exp_rr_sin[got]);
                got++;
            end
        end
        chk("rr_count", got, 4);
        chk("rr_onehot", onehot_bad, 0);
        @(posedge clk); #1;

        // Backpressure: hold rsp_ready low with port 1 waiting.
        sif.rsp_ready = 1'b0;
        sif.req_theta[0*DW +: DW] = 16'h1555;
        sif.req_theta[1*DW +: DW] = 16'h0000;
        sif.req_valid = 4'b0011;
        #1;
        chk("bp_grant", sif.req_ready, 4'b0001);
        @(posedge clk); #1;
        sif.req_valid[0] = 1'b0;
        cyc = 1;
        while (!sif.rsp_valid && cyc < 60) begin
            @(posedge clk); #1; cyc++;
        end
        chk("bp_latency", cyc, CC + 1);
        chk("bp_rsp_id", sif.rsp_id, 0);
        chk_near("bp_rsp_sine", sif.rsp_sine, 2048);
        s0 = sif.rsp_sine;
        c0 = sif.rsp_cosine;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (sif.rsp_valid !== 1'b1 || sif.rsp_sine !== s0 || sif.rsp_cosine !== c0 ||
                sif.rsp_id !== 2'd0 || sif.req_ready !== 4'b0 || core_valid !== 1'b0 || busy !== 1'b1)
                bad++;
        end
        chk("bp_stall_cycles_bad", bad, 0);
        sif.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rsp_drop", sif.rsp_valid, 0);
        chk("bp_next_grant", sif.req_ready, 4'b0010);
        @(posedge clk); #1;
        sif.req_valid[1] = 1'b0;
        chk("bp_next_core_valid", core_valid, 1);
        chk("bp_next_core_theta", core_theta, 16'h0000);
        cyc = 1;
        while (!sif.rsp_valid && cyc < 60) begin
            @(posedge clk); #1; cyc++;
        end
        chk("bp_next_latency", cyc, CC + 1);
        chk("bp_next_id", sif.rsp_id, 1);
        chk_near("bp_next_cosine", sif.rsp_cosine, Q_ONE);
        @(posedge clk); #1;

        // Reset in the middle of RUN drops the job and rewinds rr_ptr.
        sif.req_theta[2*DW +: DW] = 16'h1000;
        sif.req_valid[2] = 1'b1;
        #1;
        chk("rst_test_grant", sif.req_ready, 4'b0100);
        @(posedge clk); #1;
        sif.req_valid[2] = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("run_before_rst", core_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_core_valid", core_valid, 0);
        chk("mid_rst_rsp_valid", sif.rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        sif.req_theta[3*DW +: DW] = 16'hD555;
        sif.req_theta[0*DW +: DW] = 16'h0000;
        sif.req_valid = 4'b1001;
        #1;
        chk("mid_rst_req_ready", sif.req_ready, 0);
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (sif.rsp_valid) seen++;
        end
        chk("rst_no_response", seen, 0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_grant", sif.req_ready, 4'b0001);
        run_job(0, 16'h0000, 16'h0000, 0, Q_ONE);
        run_job(3, 16'hD555, 16'hD555, -3547, 2048);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
